bayer_gs_pipe: RTL and testbench
================================

# bayer_gs_pipe

Parametrised Bayer-mosaic-to-greyscale stage that sits between the two-row line buffer and the downstream image path. It forms a 2x2 window from the buffer's upper and lower taps and produces greyscale pixels in one of two run-time modes. Decimated mode produces one pixel per 2x2 block. Full-rate mode produces one pixel per position, with Bayer-phase weighting. The stage tracks frame position internally from a start-of-frame strobe, and marks output frame boundaries.

## Interface
Clock `clk`; reset `rst` is asynchronous and active-low.

Parameters:
- DW, 12, pixel data width
- CW, 11, coordinate width
- WIDTH, 1280, input pixels per row (even, >=4)
- HEIGHT, 960, input rows per frame (even, >=4)

Ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- data_in_1  in  DW  lower-row tap (row y)
- data_in_2  in  DW  upper-row tap (row y-1)
- in_valid  in  1  tap pair valid this cycle
- in_sof  in  1  qualifies pixel (0,0); meaningful only with in_valid
- mode  in  1  0 = decimated average, 1 = full-rate weighted; latched at sof
- black_lvl  in  DW  black level (used only with GS_BLACKLVL_EN)
- gs_out  out  DW  greyscale pixel
- out_valid  out  1  gs_out/x_out/y_out valid
- x_out, y_out  out  CW each  output-frame coordinates
- out_sof  out  1  with first output pixel of frame
- out_eof  out  1  with last output pixel of frame
- sync_err  out  1  one-cycle pulse on early/late sof

## Operation
- States WAIT_SOF (reset) and ACTIVE.
  - WAIT_SOF: in_valid without in_sof is ignored.
  - in_valid & in_sof moves to ACTIVE: col=0, row=0, mode_q=mode.
- ACTIVE, per accepted tap pair:
  - col++; at WIDTH-1, col=0 and row++.
  - At (WIDTH-1, HEIGHT-1), return to WAIT_SOF.
- Sof while ACTIVE restarts the frame at (0,0) and pulses sync_err.
- A frame that ends without the next sof also pulses sync_err on the first in_valid seen in WAIT_SOF, if that in_valid carries no sof.
- Window: p01=data_in_2, p11=data_in_1 (current column); p00, p10 hold the previous accepted column. Window registers shift only on accepted in_valid.
- Emit conditions:
  - Decimated (mode_q=0): col and row both odd. x_out=col>>1, y_out=row>>1. Output frame is WIDTH/2 x HEIGHT/2.
  - Full-rate (mode_q=1): col>=1 and row>=1. x_out=col-1, y_out=row-1. Output frame is (WIDTH-1) x (HEIGHT-1).
  - col=0 never emits, so there is no cross-row window mixing.
- Arithmetic: all sums are DW+3 bits wide, with no intermediate overflow. Results are truncated.
  - Decimated: (p00+p01+p10+p11)>>2.
  - Full-rate, phase=(col^row)&1:
    - Phase 0: (3*(p00+p11)+p01+p10)>>3.
    - Phase 1: (p00+p11+3*(p01+p10))>>3.
- out_sof: first emitted pixel of the frame (output coordinates 0,0).
- out_eof: last emitted pixel of the frame.
- A mode change mid-frame takes effect only at the next sof.

## Timing
- Latency 2 edges: a pair accepted at edge E gives registered outputs valid after edge E+1. Window registers update at E; output registers update at E+1.
- One output per accepted input at most; no backpressure.
- Gaps in in_valid stall counters and window. out_valid deasserts on any cycle with no emit.
- Reset values:
  - gs_out, x_out, y_out: 0
  - out_valid, out_sof, out_eof, sync_err: 0
  - state: WAIT_SOF; mode_q: 0; window registers: 0
- Reset mid-frame discards the window and in-flight output. The block resumes only at the next sof.
- in_sof and in_valid on the same edge as the final pixel of a frame: the sof pixel wins, and the new frame starts.
- sync_err, out_sof and out_eof are registered with out_valid timing (E+1).

## Configuration
- GS_BLACKLVL_EN defined: gs_out = max(result - black_lvl, 0), computed in the same output register stage. Latency is unchanged.
- GS_BLACKLVL_EN undefined: black_lvl is ignored and gs_out = result.

## Test plan
- Decimated, WIDTH=4, HEIGHT=4, every pixel 100, sof on first:
  - out_valid pulses 4 times with gs_out=100 and coordinates (0,0),(1,0),(0,1),(1,1).
  - out_sof on the first, out_eof on the last; each 2 edges after its input pair.
- Full-rate, 4x4, with p00=8, p01=0, p10=0, p11=8 at (col,row)=(1,1) (phase 0):
  - gs_out=6 at x_out=0, y_out=0.
  - The same window at phase 1 gives gs_out=2.
- Saturation, DW=12, all 4095, both modes: gs_out=4095 with no wrap.
- Mid-frame sof at row 2: sync_err pulses once, counters restart, and the next out_sof occurs at output (0,0).
- in_valid toggled every other cycle: output count and values are identical to the gap-free run. Async reset asserted mid-frame clears all outputs to 0 immediately.
- GS_BLACKLVL_EN defined, black_lvl=150, pixels 100: gs_out=0. With pixels 400: gs_out=250.

Source files
------------

// File: rtl/bayer_gs_pipe.sv
// bayer_gs_pipe: 2x2 Bayer window to greyscale, decimated or full-rate; GS_BLACKLVL_EN adds black-level clamp
module bayer_gs_pipe #(
  parameter int DW     = 12,
  parameter int CW     = 11,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in_1,
  input  logic [DW-1:0] data_in_2,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          mode,
  input  logic [DW-1:0] black_lvl,
  output logic [DW-1:0] gs_out,
  output logic          out_valid,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out,
  output logic          out_sof,
  output logic          out_eof,
  output logic          sync_err
);
  typedef enum logic {WAIT_SOF, ACTIVE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] col_q, row_q, col_d, row_d, pc, pr, x_d, y_d, x1_q, y1_q;
  logic          mode_q, mode_d, acc, eol, last, emit_d, err_d, ended_q;
  logic [DW-1:0] p00_q, p01_q, p10_q, p11_q;
  logic          v1_q, sof1_q, eof1_q, err1_q, ph1_q, m1_q;
  logic [DW+2:0] s_diag, s_anti, wide;
  logic [DW-1:0] res, gs_d;
  logic          unused_hi;

  // position of the incoming pair (a sof pair is always (0,0)) and what it will emit
  always_comb begin
    acc     = in_valid & (in_sof | (state_q == ACTIVE));
    pc      = in_sof ? '0 : col_q;
    pr      = in_sof ? '0 : row_q;
    mode_d  = in_sof ? mode : mode_q;
    eol     = pc == CW'(WIDTH - 1);
    last    = eol & (pr == CW'(HEIGHT - 1));
    col_d   = eol ? '0 : pc + CW'(1);
    row_d   = eol ? pr + CW'(1) : pr;
    state_d = last ? WAIT_SOF : ACTIVE;
    emit_d  = acc & (mode_d ? (pc != '0) & (pr != '0) : pc[0] & pr[0]);
    x_d     = mode_d ? pc - CW'(1) : pc >> 1;
    y_d     = mode_d ? pr - CW'(1) : pr >> 1;
    err_d   = in_valid & (in_sof ? state_q == ACTIVE : (state_q == WAIT_SOF) & ended_q);
  end

  // frame tracking, window shift and first pipeline stage; ended_q flags a frame closed without a fresh sof
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_SOF;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= 1'b0;
      ended_q <= 1'b0;
      p00_q   <= '0;
      p01_q   <= '0;
      p10_q   <= '0;
      p11_q   <= '0;
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      eof1_q  <= 1'b0;
      err1_q  <= 1'b0;
      ph1_q   <= 1'b0;
      m1_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else begin
      if (acc) begin
        state_q <= state_d;
        col_q   <= col_d;
        row_q   <= row_d;
        mode_q  <= mode_d;
        ended_q <= last;
        p00_q   <= p01_q;
        p10_q   <= p11_q;
        p01_q   <= data_in_2;
        p11_q   <= data_in_1;
      end else if (in_valid) begin
        ended_q <= 1'b0;
      end
      v1_q   <= emit_d;
      sof1_q <= emit_d & (pc == CW'(1)) & (pr == CW'(1));
      eof1_q <= emit_d & last;
      err1_q <= err_d;
      ph1_q  <= pc[0] ^ pr[0];
      m1_q   <= mode_d;
      x1_q   <= x_d;
      y1_q   <= y_d;
    end
  end

  // window arithmetic in DW+3 bits so the x3 weights cannot overflow before the shift
  always_comb begin
    s_diag = (DW+3)'(p00_q) + (DW+3)'(p11_q);
    s_anti = (DW+3)'(p01_q) + (DW+3)'(p10_q);
    wide   = !m1_q ? (s_diag + s_anti) >> 2 :
             ph1_q ? (s_diag + (s_anti << 1) + s_anti) >> 3 :
                     ((s_diag << 1) + s_diag + s_anti) >> 3;
    res    = wide[DW-1:0];
`ifdef GS_BLACKLVL_EN
    gs_d   = (res > black_lvl) ? res - black_lvl : '0;
`else
    gs_d   = res;
`endif
  end

  assign unused_hi = ^{wide[DW+2:DW], black_lvl};

  // output register stage; data holds its last value while out_valid is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gs_out    <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= v1_q;
      out_sof   <= sof1_q;
      out_eof   <= eof1_q;
      sync_err  <= err1_q;
      if (v1_q) begin
        gs_out <= gs_d;
        x_out  <= x1_q;
        y_out  <= y1_q;
      end
    end
  end
endmodule

// File: tb/tb_bayer_gs_pipe.sv
// tb_bayer_gs_pipe: directed-vector bench for bayer_gs_pipe on a 4x4 frame
module tb_bayer_gs_pipe;
  localparam int DW = 12, CW = 11, W = 4, H = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic [DW-1:0] data_in_1 = '0, data_in_2 = '0, black_lvl = '0;
  logic          in_valid = 1'b0, in_sof = 1'b0, mode = 1'b0;
  logic [DW-1:0] gs_out;
  logic          out_valid, out_sof, out_eof, sync_err;
  logic [CW-1:0] x_out, y_out;

  bayer_gs_pipe #(.DW(DW), .CW(CW), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .in_valid(in_valid), .in_sof(in_sof), .mode(mode), .black_lvl(black_lvl),
    .gs_out(gs_out), .out_valid(out_valid), .x_out(x_out), .y_out(y_out),
    .out_sof(out_sof), .out_eof(out_eof), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m;
    int   u0, u1, l0, l1;
    logic gap;
    int   bl;
    int   e_odd, e_even;
  } vec_t;

  typedef struct {
    int   gs, x, y;
    logic s, e;
    int   cyc;
  } out_t;

  out_t q[$];
  vec_t tv[11];
  int   cyc = 0, serr = 0, t11 = 0, n_chk = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid)
      q.push_back('{gs: int'(gs_out), x: int'(x_out), y: int'(y_out), s: out_sof, e: out_eof, cyc: cyc});
    if (sync_err) serr++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic pix(input logic s, input vec_t v, input int i);
    int c, r;
    c = i % W;
    r = (i / W) % H;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_sof    = s;
    mode      = s ? v.m : ~v.m;
    black_lvl = DW'(v.bl);
    data_in_2 = DW'(c[0] ? v.u1 : v.u0);
    data_in_1 = DW'(c[0] ? v.l1 : v.l0);
    if (c == 1 && r == 1) t11 = cyc;
    if (v.gap) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic send(input vec_t v, input int n, input logic sof);
    for (int i = 0; i < n; i++) pix(sof && i == 0, v, i);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic check_frame(input vec_t v, input int k);
    int ow, ne, ey, exp;
    ow = v.m ? W - 1 : W / 2;
    ne = v.m ? (W - 1) * (H - 1) : (W * H) / 4;
    chk($sformatf("v%0d count", k), q.size(), ne);
    chk($sformatf("v%0d sync_err", k), serr, 0);
    if (q.size() > 0) chk($sformatf("v%0d latency", k), q[0].cyc - t11, 2);
    for (int i = 0; i < q.size() && i < ne; i++) begin
      ey  = i / ow;
      exp = (v.m ? ((ey + 1) % 2 == 1) : 1'b1) ? v.e_odd : v.e_even;
      chk($sformatf("v%0d[%0d] x", k, i), q[i].x, i % ow);
      chk($sformatf("v%0d[%0d] y", k, i), q[i].y, ey);
      chk($sformatf("v%0d[%0d] gs", k, i), q[i].gs, exp);
      chk($sformatf("v%0d[%0d] sof", k, i), int'(q[i].s), int'(i == 0));
      chk($sformatf("v%0d[%0d] eof", k, i), int'(q[i].e), int'(i == ne - 1));
    end
  endtask

  initial begin
    tv[0]  = '{m: 0, u0: 100,  u1: 100,  l0: 100,  l1: 100,  gap: 0, bl: 0,   e_odd: 100,  e_even: 100};
    tv[1]  = '{m: 1, u0: 8,    u1: 0,    l0: 0,    l1: 8,    gap: 0, bl: 0,   e_odd: 6,    e_even: 2};
    tv[2]  = '{m: 1, u0: 4095, u1: 4095, l0: 4095, l1: 4095, gap: 0, bl: 0,   e_odd: 4095, e_even: 4095};
    tv[3]  = '{m: 0, u0: 4095, u1: 4095, l0: 4095, l1: 4095, gap: 0, bl: 0,   e_odd: 4095, e_even: 4095};
    tv[4]  = '{m: 0, u0: 10,   u1: 30,   l0: 20,   l1: 41,   gap: 0, bl: 0,   e_odd: 25,   e_even: 25};
    tv[5]  = '{m: 1, u0: 10,   u1: 30,   l0: 20,   l1: 41,   gap: 0, bl: 0,   e_odd: 25,   e_even: 25};
    tv[6]  = '{m: 1, u0: 8,    u1: 0,    l0: 0,    l1: 8,    gap: 1, bl: 0,   e_odd: 6,    e_even: 2};
    tv[7]  = '{m: 0, u0: 100,  u1: 100,  l0: 100,  l1: 100,  gap: 1, bl: 0,   e_odd: 100,  e_even: 100};
    tv[8]  = '{m: 1, u0: 0,    u1: 100,  l0: 50,   l1: 0,    gap: 0, bl: 0,   e_odd: 18,   e_even: 56};
`ifdef GS_BLACKLVL_EN
    tv[9]  = '{m: 0, u0: 100,  u1: 100,  l0: 100,  l1: 100,  gap: 0, bl: 150, e_odd: 0,    e_even: 0};
    tv[10] = '{m: 0, u0: 400,  u1: 400,  l0: 400,  l1: 400,  gap: 0, bl: 150, e_odd: 250,  e_even: 250};
`else
    tv[9]  = '{m: 0, u0: 100,  u1: 100,  l0: 100,  l1: 100,  gap: 0, bl: 150, e_odd: 100,  e_even: 100};
    tv[10] = '{m: 0, u0: 400,  u1: 400,  l0: 400,  l1: 400,  gap: 0, bl: 150, e_odd: 400,  e_even: 400};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset gs_out", int'(gs_out), 0);
    chk("reset sync_err", int'(sync_err), 0);
    chk("reset out_sof", int'(out_sof), 0);
    rst = 1'b1;

    for (int k = 0; k < 11; k++) begin
      q.delete();
      serr = 0;
      send(tv[k], W * H, 1'b1);
      idle(4);
      check_frame(tv[k], k);
    end

    // sof arriving at row 2 restarts the frame
    q.delete();
    serr = 0;
    send(tv[0], 2 * W, 1'b1);
    send(tv[0], W * H, 1'b1);
    idle(4);
    chk("midsof count", q.size(), 6);
    chk("midsof sync_err", serr, 1);
    if (q.size() == 6) begin
      chk("midsof first sof", int'(q[0].s), 1);
      chk("midsof cut eof", int'(q[1].e), 0);
      chk("midsof restart sof", int'(q[2].s), 1);
      chk("midsof restart x", q[2].x, 0);
      chk("midsof restart y", q[2].y, 0);
      chk("midsof last eof", int'(q[5].e), 1);
    end

    // pixel after a finished frame without sof flags once and is ignored
    q.delete();
    serr = 0;
    pix(1'b0, tv[0], 0);
    idle(3);
    chk("late sync_err", serr, 1);
    pix(1'b0, tv[0], 1);
    idle(3);
    chk("late sync_err once", serr, 1);
    chk("late no output", q.size(), 0);

    // sof on the final pixel slot: new frame wins, old frame never sees eof
    q.delete();
    serr = 0;
    send(tv[0], W * H - 1, 1'b1);
    send(tv[0], W * H, 1'b1);
    idle(4);
    chk("sof@last count", q.size(), 7);
    chk("sof@last sync_err", serr, 1);
    if (q.size() == 7) begin
      chk("sof@last old eof", int'(q[2].e), 0);
      chk("sof@last new sof", int'(q[3].s), 1);
      chk("sof@last new eof", int'(q[6].e), 1);
    end

    // async reset mid-frame, then pixels without sof stay ignored
    q.delete();
    serr = 0;
    send(tv[0], 2 * W, 1'b1);
    idle(1);
    #1;
    chk("prerst out_valid", int'(out_valid), 1);
    chk("prerst x_out", int'(x_out), 1);
    rst = 1'b0;
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst gs_out", int'(gs_out), 0);
    chk("rst x_out", int'(x_out), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    for (int i = 2 * W; i < W * H; i++) pix(1'b0, tv[0], i);
    idle(4);
    chk("postrst no output", q.size(), 0);
    chk("postrst sync_err", serr, 0);
    q.delete();
    send(tv[1], W * H, 1'b1);
    idle(4);
    check_frame(tv[1], 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
